// File: rtl/pack_arb_pkg.sv
// pack_arb_pkg: shared types and constants for pack_11byte_arbiter.
// Frame layout: byte 0 is the header {seq, src}, bytes 1..10 the payload.
package pack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;

    localparam int PAYLOAD_W   = 80;
    localparam int FRAME_W     = 88;
    localparam int HDR_W       = 8;
    localparam int IDX_W       = 4;
    localparam int SEQ_W       = 4;
    localparam int HDR_SRC_LSB = 0;
    localparam int HDR_SEQ_LSB = 4;

    localparam logic [7:0] IDLE_K = 8'hBC;

    // Advance an index by one, wrapping n-1 back to 0.
    function automatic logic [IDX_W-1:0] wrap_inc(
        input logic [IDX_W-1:0] v,
        input int               n
    );
        if (int'(v) >= n - 1) begin
            return '0;
        end
        return v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/pack_11byte_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Searches from ptr_i upward, wrapping modulo N; first request wins.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   pos;

    // Rotating priority scan starting at the pointer.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr_i) + k) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/pack_11byte_arbiter.sv
// pack_11byte_arbiter: round-robin scheduler sharing one 11-byte packer.
// Optional busy watchdog enabled by defining PACK_ARB_WATCHDOG_EN.
module pack_11byte_arbiter
    import pack_arb_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC*PAYLOAD_W-1:0] src_data,
    output logic [N_SRC-1:0]           src_ready,
    output logic                       pk_valid,
    output logic [FRAME_W-1:0]         pk_data,
    input  logic                       pk_busy,
    output logic [IDX_W-1:0]           grant_src,
    output logic                       err
);

    arb_state_e         state_q, state_d;
    logic [N_SRC-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               fire;
    logic               wd_expire;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [SEQ_W-1:0]   seq_q;
    logic               pk_valid_q;
    logic [FRAME_W-1:0] pk_data_q;
    logic [HDR_W-1:0]   hdr;

    rr_picker #(
        .N  (N_SRC),
        .IW (IDX_W)
    ) u_pick (
        .req_i (src_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant, pulse, then follow the packer busy cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (pk_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!pk_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: accept only from IDLE while the packer is free.
    always_comb begin
        fire      = (state_q == IDLE) && !rst && !pk_busy && pick_any;
        src_ready = fire ? pick_gnt : '0;
    end

    // Header byte for the frame being accepted this cycle.
    always_comb begin
        hdr                           = '0;
        hdr[HDR_SRC_LSB +: IDX_W]     = pick_idx;
        hdr[HDR_SEQ_LSB +: SEQ_W]     = seq_q;
    end

    // Frame capture, sequence counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_valid_q <= 1'b0;
            pk_data_q  <= '0;
            grant_q    <= '0;
            seq_q      <= '0;
            rr_ptr_q   <= '0;
        end else begin
            pk_valid_q <= fire;
            if (fire) begin
                pk_data_q <= {src_data[PAYLOAD_W*int'(pick_idx) +: PAYLOAD_W], hdr};
                grant_q   <= pick_idx;
                seq_q     <= seq_q + SEQ_W'(1);
                rr_ptr_q  <= wrap_inc(pick_idx, N_SRC);
            end
        end
    end

    assign pk_valid  = pk_valid_q;
    assign pk_data   = pk_data_q;
    assign grant_src = grant_q;

`ifdef PACK_ARB_WATCHDOG_EN
    localparam int                WD_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(BUSY_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q;

    assign wd_expire = (state_q == WAIT_BUSY) && !pk_busy
                     && (wd_cnt_q == WD_LAST);

    // Count cycles spent waiting for busy to rise.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == WAIT_BUSY) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Watchdog counter and one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= wd_expire;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^BUSY_TIMEOUT;
    assign wd_expire      = 1'b0;
    assign err            = 1'b0;
`endif

endmodule
